// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the single write port of the register file. After reset it runs a
//   clear pass that zeroes registers 0..NUM_REGS-1, then shares the port
//   round-robin between NUM_REQ writers, one write per clock.
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   req_valid      per-requester pending write
//   req_dest       packed dest addresses, slice [i*ADDR_W +: ADDR_W]
//   req_data       packed write data,     slice [i*DATA_W +: DATA_W]
//   req_ready      one-hot grant (combinational); transfer = valid & ready
//   rf_write_en    register file write enable
//   rf_write_dest  register file write address
//   rf_write_data  register file write data
//   grant_id       index of the last accepted requester
//   init_done      clear pass finished, arbitration live
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_dest,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rf_write_en,
    output logic [ADDR_W-1:0]            rf_write_dest,
    output logic [DATA_W-1:0]            rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         init_done
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    // One extra bit so the counter can reach NUM_REGS, marking the pass done.
    localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   clear_cnt;
    logic [PTR_W-1:0]   rr_ptr;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic [NUM_REQ-1:0] grant_oh;
    logic [ADDR_W-1:0]  sel_dest;
    logic [DATA_W-1:0]  sel_data;

    // Round-robin search starting at rr_ptr; only live once the clear pass is done.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        grant_oh    = '0;
        if (state == ST_RUN) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found    = 1'b1;
                    grant_idx      = cand;
                    grant_oh[cand] = 1'b1;
                end
            end
        end
        sel_dest = req_dest[grant_idx*ADDR_W +: ADDR_W];
        sel_data = req_data[grant_idx*DATA_W +: DATA_W];
    end

    assign req_ready = grant_oh;

    // Clear-pass sequencing, then registered write-port drive for each grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_CLEAR;
            clear_cnt     <= '0;
            rr_ptr        <= '0;
            rf_write_en   <= 1'b0;
            rf_write_dest <= '0;
            rf_write_data <= '0;
            grant_id      <= '0;
            init_done     <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_cnt < CNT_W'(NUM_REGS)) begin
                        rf_write_en   <= 1'b1;
                        rf_write_dest <= ADDR_W'(clear_cnt);
                        rf_write_data <= '0;
                        clear_cnt     <= clear_cnt + CNT_W'(1);
                    end else begin
                        state       <= ST_RUN;
                        rf_write_en <= 1'b0;
                        init_done   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant_found) begin
                        // r0 is reserved for the clear pass: accept, but never write it.
                        rf_write_en   <= (sel_dest != '0);
                        rf_write_dest <= sel_dest;
                        rf_write_data <= sel_data;
                        grant_id      <= grant_idx;
                        rr_ptr        <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                            : grant_idx + PTR_W'(1);
                    end else begin
                        rf_write_en <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Scoreboard bench: expected register writes are queued when the model sees
//   a clear step or a transfer, then popped when the DUT asserts rf_write_en.
module tb_regfile_write_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_dest;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              rf_write_en;
    logic [AW-1:0]     rf_write_dest;
    logic [DW-1:0]     rf_write_data;
    logic [1:0]        grant_id;
    logic              init_done;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NUM_REGS(NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_dest     (req_dest),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_write_en  (rf_write_en),
        .rf_write_dest(rf_write_dest),
        .rf_write_data(rf_write_data),
        .grant_id     (grant_id),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW+DW-1:0] sb[$];

    // Reference model state
    bit m_run;
    int m_cnt;
    int m_ptr;
    int m_gid;
    bit auto_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_cnt = 0;
        m_ptr = 0;
        m_gid = 0;
        sb.delete();
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] d,
                           input logic [DW-1:0] x);
        req_valid[i]        = v;
        req_dest[i*AW +: AW] = d;
        req_data[i*DW +: DW] = x;
    endtask

    // One clock: check the grant before the edge, then the registered write after it.
    task automatic cycle();
        logic [N-1:0]     exp_ready;
        logic             exp_en;
        int               g;
        logic [AW-1:0]    d;
        logic [DW-1:0]    x;
        logic [AW+DW-1:0] e;
        #1;
        exp_ready = '0;
        g = -1;
        if (m_run) begin
            for (int i = 0; i < int'(N); i++) begin
                int c;
                c = (m_ptr + i) % int'(N);
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        exp_en = 1'b0;
        if (!m_run) begin
            if (m_cnt < int'(NR)) begin
                exp_en = 1'b1;
                sb.push_back({AW'(m_cnt), DW'(0)});
                m_cnt++;
            end else begin
                m_run = 1'b1;
            end
        end else if (g >= 0) begin
            d = req_dest[g*AW +: AW];
            x = req_data[g*DW +: DW];
            m_gid = g;
            m_ptr = (g + 1) % int'(N);
            if (d != '0) begin
                exp_en = 1'b1;
                sb.push_back({d, x});
            end
        end
        @(negedge clk);
        check("rf_write_en", 64'(rf_write_en), 64'(exp_en));
        check("init_done", 64'(init_done), 64'(m_run));
        check("grant_id", 64'(grant_id), 64'(m_gid));
        check("sb_pending", 64'(sb.size()), 64'(rf_write_en));
        if (rf_write_en && sb.size() != 0) begin
            e = sb.pop_front();
            check("rf_write", 64'({rf_write_dest, rf_write_data}), 64'(e));
        end
        if (auto_drop) req_valid = req_valid & ~exp_ready;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},    64'(rf_write_en),   64'(0));
        check({tag, "_dest"},  64'(rf_write_dest), 64'(0));
        check({tag, "_data"},  64'(rf_write_data), 64'(0));
        check({tag, "_gid"},   64'(grant_id),      64'(0));
        check({tag, "_init"},  64'(init_done),     64'(0));
        check({tag, "_ready"}, 64'(req_ready),     64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_dest  = '0;
        req_data  = '0;
        auto_drop = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Clear pass with no requests
        repeat (NR + 1) cycle();
        check("t1_init_done", 64'(init_done), 64'(1));

        // All four valid and held: strict rotation
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'hA0 + i));
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t2_order", 64'(grant_id), 64'(k % 4));
            check("t2_dest", 64'(rf_write_dest), 64'(k % 4 + 1));
        end
        req_valid = '0;

        // Lone requester gets every cycle
        set_req(2, 1'b1, AW'(5), 32'hDEADBEEF);
        repeat (3) begin
            cycle();
            check("t3_dest", 64'(rf_write_dest), 64'(5));
            check("t3_gid", 64'(grant_id), 64'(2));
        end
        req_valid = '0;
        set_req(1, 1'b1, AW'(6), 32'h11);
        set_req(3, 1'b1, AW'(7), 32'h33);
        auto_drop = 1'b1;
        cycle();
        check("t3_first", 64'(grant_id), 64'(3));
        cycle();
        check("t3_second", 64'(grant_id), 64'(1));

        // Dest 0: accepted, not written, pointer still advances
        set_req(0, 1'b1, AW'(0), 32'hFFFF_FFFF);
        cycle();
        check("t4_en", 64'(rf_write_en), 64'(0));
        check("t4_gid", 64'(grant_id), 64'(0));
        set_req(0, 1'b1, AW'(8), 32'h80);
        set_req(1, 1'b1, AW'(9), 32'h90);
        cycle();
        check("t4_ptr", 64'(grant_id), 64'(1));
        cycle();
        check("t4_wrap", 64'(grant_id), 64'(0));
        req_valid = '0;

        // Reset in the middle of the clear pass
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (18) cycle();
        check("t5_dest17", 64'(rf_write_dest), 64'(17));
        #2 rst = 1'b1;
        #1 check_reset_outputs("t5_async");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Request pending through the restarted clear pass
        set_req(1, 1'b1, AW'(10), 32'hCAFE);
        repeat (NR + 1) cycle();
        cycle();
        check("t6_gid", 64'(grant_id), 64'(1));
        check("t6_en", 64'(rf_write_en), 64'(1));
        check("t6_dest", 64'(rf_write_dest), 64'(10));
        check("t6_data", 64'(rf_write_data), 64'(32'hCAFE));
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
